// File: rtl/cw305_heep_bridge_pkg.sv
// Shared types and constants for the CW305 to X-HEEP OBI bridge.
package cw305_heep_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR_ACK  = 3'd1,
        ST_REQ       = 3'd2,
        ST_RESP      = 3'd3,
        ST_INSTR_ACK = 3'd4,
        ST_RD_REQ    = 3'd5,
        ST_RD_RESP   = 3'd6
    } state_t;

    localparam int BRIDGE_EN_BIT   = 0;
    localparam int INSTR_VALID_BIT = 1;
    localparam int ADDR_VALID_BIT  = 2;

    localparam logic [3:0] DATA_BE = 4'hF;

    // Word pointer advance; the top word wraps to address zero.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr);
        return ptr + 32'd4;
    endfunction

endpackage

// File: rtl/cw305_bridge_watchdog.sv
// Cycle counter that flags the pTIMEOUT-th consecutive cycle spent waiting on the OBI slave.
module cw305_bridge_watchdog #(
    parameter int pTIMEOUT   = 255,
    parameter int pTIMEOUT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [pTIMEOUT_W-1:0] LIMIT = pTIMEOUT_W'(pTIMEOUT - 1);

    logic [pTIMEOUT_W-1:0] count;

    // Saturates at the limit so a stalled state can never wrap back to a fresh count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + pTIMEOUT_W'(1);
        end
    end

    assign expired = count_en && (count == LIMIT);

endmodule

// File: rtl/cw305_heep_bridge.sv
// Turns CW305 host-written address/instruction registers into OBI writes into X-HEEP memory.
// Define CW305_BRIDGE_READBACK_EN to follow every write with an OBI read of the same word.
module cw305_heep_bridge
    import cw305_heep_bridge_pkg::*;
#(
    parameter int pINSTR_WIDTH = 32,
    parameter int pTIMEOUT     = 255,
    parameter int pTIMEOUT_W   = 8
) (
    input  logic                    usb_clk,
    input  logic                    reset_i,
    input  logic [7:0]              I_status,
    input  logic [pINSTR_WIDTH-1:0] I_instruction,
    input  logic [pINSTR_WIDTH-1:0] I_address,
    output logic                    O_reset_new_addr_valid,
    output logic                    O_reset_instr_valid,
    output logic [pINSTR_WIDTH-1:0] O_heep_data,
    output logic                    O_data_req,
    input  logic                    I_data_gnt,
    output logic [pINSTR_WIDTH-1:0] O_data_addr,
    output logic                    O_data_we,
    output logic [3:0]              O_data_be,
    output logic [pINSTR_WIDTH-1:0] O_data_wdata,
    input  logic                    I_data_rvalid,
    input  logic [pINSTR_WIDTH-1:0] I_data_rdata,
    output logic                    O_busy,
    output logic                    O_error
);

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [pINSTR_WIDTH-1:0] addr_q, addr_d;
    logic [pINSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic [pINSTR_WIDTH-1:0] heep_q, heep_d;
    logic [pINSTR_WIDTH-1:0] ptr_q, ptr_d;
    logic                    err_q, err_d;
    logic                    waiting;
    logic                    expired;

    assign waiting = (state_q == ST_REQ) || (state_q == ST_RESP) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

    // Any state change restarts the watchdog, so each wait phase gets the full budget.
    cw305_bridge_watchdog #(
        .pTIMEOUT   (pTIMEOUT),
        .pTIMEOUT_W (pTIMEOUT_W)
    ) u_watchdog (
        .clk      (usb_clk),
        .reset    (reset_i),
        .clear    (state_d != state_q),
        .count_en (waiting),
        .expired  (expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        heep_d  = heep_q;
        ptr_d   = ptr_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (I_status[BRIDGE_EN_BIT]) begin
                    if (I_status[ADDR_VALID_BIT]) begin
                        state_d = ST_ADDR_ACK;
                    end else if (I_status[INSTR_VALID_BIT]) begin
                        wdata_d = I_instruction;
                        addr_d  = ptr_q;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_ADDR_ACK: begin
                ptr_d   = {I_address[pINSTR_WIDTH-1:2], 2'b00};
                state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (I_data_gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_INSTR_ACK;
                end
            end
            ST_RESP: begin
                if (I_data_rvalid) begin
                    heep_d = wdata_q;
                    ptr_d  = next_ptr(ptr_q);
`ifdef CW305_BRIDGE_READBACK_EN
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    state_d = ST_RD_REQ;
`else
                    state_d = ST_INSTR_ACK;
`endif
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_INSTR_ACK;
                end
            end
`ifdef CW305_BRIDGE_READBACK_EN
            ST_RD_REQ: begin
                if (I_data_gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_RD_RESP;
                end else if (expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_INSTR_ACK;
                end
            end
            ST_RD_RESP: begin
                if (I_data_rvalid) begin
                    heep_d  = I_data_rdata;
                    state_d = ST_INSTR_ACK;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_INSTR_ACK;
                end
            end
`endif
            ST_INSTR_ACK: begin
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            heep_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            heep_q  <= heep_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Acks are decoded from the registered state, so each is a clean one-cycle low pulse.
    assign O_reset_new_addr_valid = (state_q != ST_ADDR_ACK);
    assign O_reset_instr_valid    = (state_q != ST_INSTR_ACK);
    assign O_busy                 = (state_q != ST_IDLE);
    assign O_error                = err_q;
    assign O_data_req             = req_q;
    assign O_data_we              = we_q;
    assign O_data_addr            = addr_q;
    assign O_data_wdata           = wdata_q;
    assign O_data_be              = DATA_BE;
    assign O_heep_data            = heep_q;

    logic unused_inputs;
`ifdef CW305_BRIDGE_READBACK_EN
    assign unused_inputs = ^{I_status[7:3], I_address[1:0]};
`else
    assign unused_inputs = ^{I_status[7:3], I_address[1:0], I_data_rdata};
`endif

endmodule

// File: tb/tb_cw305_heep_bridge.sv
// Directed bench for cw305_heep_bridge: models the host register block and an OBI slave.
module tb_cw305_heep_bridge;

    localparam logic [31:0] RD_WORD = 32'h1234_5678;
    localparam int          ACK_BOUND = 600;

    logic        usb_clk = 1'b0;
    logic        reset_i;
    logic [7:0]  I_status;
    logic [31:0] I_instruction;
    logic [31:0] I_address;
    logic        O_reset_new_addr_valid;
    logic        O_reset_instr_valid;
    logic [31:0] O_heep_data;
    logic        O_data_req;
    logic        I_data_gnt;
    logic [31:0] O_data_addr;
    logic        O_data_we;
    logic [3:0]  O_data_be;
    logic [31:0] O_data_wdata;
    logic        I_data_rvalid;
    logic [31:0] I_data_rdata;
    logic        O_busy;
    logic        O_error;

    logic        hold_gnt;
    int          assertions = 0;
    int          failures   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          reads         = 0;
    int          addr_acks     = 0;
    int          instr_acks    = 0;
    int          req_cycles    = 0;
    int          cyc           = 0;
    int          addr_ack_cyc  = 0;
    int          instr_ack_cyc = 0;

    always #5 usb_clk = ~usb_clk;

    cw305_heep_bridge dut (
        .usb_clk                (usb_clk),
        .reset_i                (reset_i),
        .I_status               (I_status),
        .I_instruction          (I_instruction),
        .I_address              (I_address),
        .O_reset_new_addr_valid (O_reset_new_addr_valid),
        .O_reset_instr_valid    (O_reset_instr_valid),
        .O_heep_data            (O_heep_data),
        .O_data_req             (O_data_req),
        .I_data_gnt             (I_data_gnt),
        .O_data_addr            (O_data_addr),
        .O_data_we              (O_data_we),
        .O_data_be              (O_data_be),
        .O_data_wdata           (O_data_wdata),
        .I_data_rvalid          (I_data_rvalid),
        .I_data_rdata           (I_data_rdata),
        .O_busy                 (O_busy),
        .O_error                (O_error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Passive monitor sampled mid-cycle: OBI transfers, ack pulses, request-high cycles.
    initial begin
        forever begin
            @(negedge usb_clk);
            cyc++;
            if (!O_reset_new_addr_valid) begin
                addr_acks++;
                addr_ack_cyc = cyc;
            end
            if (!O_reset_instr_valid) begin
                instr_acks++;
                instr_ack_cyc = cyc;
            end
            if (O_data_req) req_cycles++;
            if (O_data_req && I_data_gnt) begin
                if (O_data_we) begin
                    wq_addr.push_back(O_data_addr);
                    wq_data.push_back(O_data_wdata);
                end else begin
                    reads++;
                end
            end
        end
    end

    // OBI slave: grants in the request cycle unless held off, responds one cycle after grant.
    initial begin
        logic acc, acc_we;
        I_data_gnt    = 1'b0;
        I_data_rvalid = 1'b0;
        I_data_rdata  = '0;
        forever begin
            @(negedge usb_clk);
            acc    = O_data_req && I_data_gnt;
            acc_we = O_data_we;
            @(posedge usb_clk);
            #1;
            I_data_rvalid = acc;
            I_data_rdata  = (acc && !acc_we) ? RD_WORD : 32'h0;
            I_data_gnt    = O_data_req && !hold_gnt;
        end
    end

    // Waits for one ack pulse, then clears the status bit at the edge that ends it.
    task automatic waitAck(input bit is_addr, input string tag);
        int n;
        n = 0;
        while (n < ACK_BOUND) begin
            @(negedge usb_clk);
            if ((is_addr ? O_reset_new_addr_valid : O_reset_instr_valid) == 1'b0) break;
            n++;
        end
        checkOutput({tag, " ack seen"}, 32'(n < ACK_BOUND), 32'd1);
        if (n < ACK_BOUND) begin
            @(posedge usb_clk);
            #1;
            if (is_addr) I_status[2] = 1'b0;
            else         I_status[1] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit do_addr, input logic [31:0] addr,
                                 input bit do_instr, input logic [31:0] instr, input string tag);
        I_address     = addr;
        I_instruction = instr;
        if (do_addr)  I_status[2] = 1'b1;
        if (do_instr) I_status[1] = 1'b1;
        if (do_addr)  waitAck(1'b1, tag);
        if (do_instr) waitAck(1'b0, tag);
    endtask

    initial begin
        int base, acks0, iacks0, reads0, reqs0, n;
        logic [31:0] heep_prev;

        reset_i       = 1'b1;
        I_status      = 8'h00;
        I_instruction = '0;
        I_address     = '0;
        hold_gnt      = 1'b0;
        repeat (3) @(posedge usb_clk);
        #1;
        checkOutput("rst addr_ack", 32'(O_reset_new_addr_valid), 32'd1);
        checkOutput("rst instr_ack", 32'(O_reset_instr_valid), 32'd1);
        checkOutput("rst req", 32'(O_data_req), 32'd0);
        checkOutput("rst we", 32'(O_data_we), 32'd0);
        checkOutput("rst addr", O_data_addr, 32'h0);
        checkOutput("rst wdata", O_data_wdata, 32'h0);
        checkOutput("rst heep", O_heep_data, 32'h0);
        checkOutput("rst busy", 32'(O_busy), 32'd0);
        checkOutput("rst error", 32'(O_error), 32'd0);
        reset_i     = 1'b0;
        I_status[0] = 1'b1;
        @(posedge usb_clk);
        #1;

        // Unaligned base address followed by a single write.
        base = wq_addr.size(); acks0 = addr_acks; iacks0 = instr_acks; reads0 = reads;
        applyStimulus(1'b1, 32'h0000_1003, 1'b0, 32'h0, "t1 addr");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "t1 instr");
        repeat (2) @(posedge usb_clk);
        #1;
        checkOutput("t1 addr ack pulses", 32'(addr_acks - acks0), 32'd1);
        checkOutput("t1 instr ack pulses", 32'(instr_acks - iacks0), 32'd1);
        checkOutput("t1 writes", 32'(wq_addr.size() - base), 32'd1);
        if (wq_addr.size() > base) begin
            checkOutput("t1 wr addr", wq_addr[base], 32'h0000_1000);
            checkOutput("t1 wr data", wq_data[base], 32'hDEAD_BEEF);
        end
        checkOutput("t1 be", 32'(O_data_be), 32'hF);
`ifdef CW305_BRIDGE_READBACK_EN
        checkOutput("t1 reads", 32'(reads - reads0), 32'd1);
        checkOutput("t1 heep", O_heep_data, RD_WORD);
`else
        checkOutput("t1 reads", 32'(reads - reads0), 32'd0);
        checkOutput("t1 heep", O_heep_data, 32'hDEAD_BEEF);
`endif
        checkOutput("t1 busy", 32'(O_busy), 32'd0);

        // Three writes from one base increment the pointer by a word each.
        base = wq_addr.size();
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 32'h0, "t2 addr");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1111_1111, "t2 i0");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2222_2222, "t2 i1");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h3333_3333, "t2 i2");
        checkOutput("t2 writes", 32'(wq_addr.size() - base), 32'd3);
        if (wq_addr.size() >= base + 3) begin
            checkOutput("t2 addr0", wq_addr[base],     32'h0000_2000);
            checkOutput("t2 addr1", wq_addr[base + 1], 32'h0000_2004);
            checkOutput("t2 addr2", wq_addr[base + 2], 32'h0000_2008);
            checkOutput("t2 data2", wq_data[base + 2], 32'h3333_3333);
        end

        // Address and instruction raised together: address is serviced first.
        base = wq_addr.size();
        applyStimulus(1'b1, 32'h0000_3000, 1'b1, 32'hCAFE_F00D, "t3 both");
        checkOutput("t3 order", 32'(addr_ack_cyc < instr_ack_cyc), 32'd1);
        checkOutput("t3 writes", 32'(wq_addr.size() - base), 32'd1);
        if (wq_addr.size() > base) begin
            checkOutput("t3 wr addr", wq_addr[base], 32'h0000_3000);
            checkOutput("t3 wr data", wq_data[base], 32'hCAFE_F00D);
        end

        // Grant withheld: abort after 255 request cycles, error sticks, pointer stays.
        base = wq_addr.size(); reqs0 = req_cycles; iacks0 = instr_acks;
        heep_prev = O_heep_data;
        hold_gnt  = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h55AA_55AA, "t4 timeout");
        hold_gnt  = 1'b0;
        checkOutput("t4 req cycles", 32'(req_cycles - reqs0), 32'd255);
        checkOutput("t4 error", 32'(O_error), 32'd1);
        checkOutput("t4 instr ack pulses", 32'(instr_acks - iacks0), 32'd1);
        checkOutput("t4 no write", 32'(wq_addr.size() - base), 32'd0);
        checkOutput("t4 heep kept", O_heep_data, heep_prev);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h7777_7777, "t4 retry");
        if (wq_addr.size() > base) checkOutput("t4 retry addr", wq_addr[base], 32'h0000_3004);
        else checkOutput("t4 retry write", 32'(wq_addr.size() - base), 32'd1);
        checkOutput("t4 error sticky", 32'(O_error), 32'd1);

        // Top-of-memory pointer wraps to zero.
        base = wq_addr.size();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, "t5 addr");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hA1A1_A1A1, "t5 i0");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hA2A2_A2A2, "t5 i1");
        if (wq_addr.size() >= base + 2) begin
            checkOutput("t5 addr top", wq_addr[base],     32'hFFFF_FFFC);
            checkOutput("t5 addr wrap", wq_addr[base + 1], 32'h0000_0000);
        end else begin
            checkOutput("t5 writes", 32'(wq_addr.size() - base), 32'd2);
        end

        // Bridge disabled: pending instruction waits until enable returns.
        base = wq_addr.size();
        I_status[0]   = 1'b0;
        I_instruction = 32'hB0B0_B0B0;
        I_status[1]   = 1'b1;
        repeat (10) @(posedge usb_clk);
        #1;
        checkOutput("t6 disabled busy", 32'(O_busy), 32'd0);
        checkOutput("t6 disabled writes", 32'(wq_addr.size() - base), 32'd0);
        I_status[0] = 1'b1;
        waitAck(1'b0, "t6 enable");
        if (wq_addr.size() > base) checkOutput("t6 wr addr", wq_addr[base], 32'h0000_0004);
        else checkOutput("t6 writes", 32'(wq_addr.size() - base), 32'd1);

        // Reset while a request is stalled.
        hold_gnt      = 1'b1;
        I_instruction = 32'h0BAD_0BAD;
        I_status[1]   = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge usb_clk);
            if (O_data_req) break;
            n++;
        end
        checkOutput("t7 req seen", 32'(n < 50), 32'd1);
        @(posedge usb_clk);
        #1;
        reset_i = 1'b1;
        @(posedge usb_clk);
        #1;
        checkOutput("t7 req", 32'(O_data_req), 32'd0);
        checkOutput("t7 busy", 32'(O_busy), 32'd0);
        checkOutput("t7 addr_ack", 32'(O_reset_new_addr_valid), 32'd1);
        checkOutput("t7 instr_ack", 32'(O_reset_instr_valid), 32'd1);
        checkOutput("t7 error", 32'(O_error), 32'd0);
        I_status[1] = 1'b0;
        hold_gnt    = 1'b0;
        reset_i     = 1'b0;
        repeat (3) @(posedge usb_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
